// File: rtl/pipe_if_pc_bpred_pkg.sv
// rtl/pipe_if_pc_bpred_pkg.sv - shared defaults, counter encodings and saturating helpers
package pipe_if_pc_bpred_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          IDX_BITS_DEF = 6;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    function automatic ctr_e sat_inc(input ctr_e c);
        case (c)
            SNT:     return WNT;
            WNT:     return WT;
            default: return ST;
        endcase
    endfunction

    function automatic ctr_e sat_dec(input ctr_e c);
        case (c)
            ST:      return WT;
            WT:      return WNT;
            default: return SNT;
        endcase
    endfunction

endpackage

// File: rtl/pipe_if_pc_bpred_btb.sv
// rtl/pipe_if_pc_bpred_btb.sv - direct-mapped BTB with 2-bit counters, comb read, sync update
module bpred_btb
    import pipe_if_pc_bpred_pkg::*;
#(
    parameter int IDX_BITS = IDX_BITS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_rd_pc,
    output logic        o_rd_taken,
    output logic [31:0] o_rd_tgt,
    input  logic        i_upd_valid,
    input  logic [31:0] i_upd_pc,
    input  logic        i_upd_taken,
    input  logic [31:0] i_upd_target
);

    localparam int N  = 1 << IDX_BITS;
    localparam int TW = 30 - IDX_BITS;

    logic            r_valid [N];
    logic [TW-1:0]   r_tag   [N];
    logic [31:0]     r_tgt   [N];
    ctr_e            r_ctr   [N];

    logic [IDX_BITS-1:0] w_rd_idx;
    logic [TW-1:0]       w_rd_tag;
    logic [IDX_BITS-1:0] w_up_idx;
    logic [TW-1:0]       w_up_tag;
    logic                w_rd_hit;
    logic                w_up_hit;

    assign w_rd_idx = i_rd_pc[IDX_BITS+1:2];
    assign w_rd_tag = i_rd_pc[31:IDX_BITS+2];
    assign w_up_idx = i_upd_pc[IDX_BITS+1:2];
    assign w_up_tag = i_upd_pc[31:IDX_BITS+2];

    assign w_rd_hit   = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
    assign w_up_hit   = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    assign o_rd_taken = w_rd_hit && r_ctr[w_rd_idx][1];
    assign o_rd_tgt   = r_tgt[w_rd_idx];

    // Read port sees pre-edge contents; an update to the same index shows up next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                r_valid[i] <= 1'b0;
                r_tag[i]   <= '0;
                r_tgt[i]   <= '0;
                r_ctr[i]   <= WNT;
            end
        end else if (i_upd_valid) begin
            if (w_up_hit) begin
                if (i_upd_taken) begin
                    r_ctr[w_up_idx] <= sat_inc(r_ctr[w_up_idx]);
                    r_tgt[w_up_idx] <= i_upd_target;
                end else begin
                    r_ctr[w_up_idx] <= sat_dec(r_ctr[w_up_idx]);
                end
            end else if (i_upd_taken) begin
                r_valid[w_up_idx] <= 1'b1;
                r_tag[w_up_idx]   <= w_up_tag;
                r_tgt[w_up_idx]   <= i_upd_target;
                r_ctr[w_up_idx]   <= WT;
            end
        end
    end

endmodule

// File: rtl/pipe_if_pc_bpred.sv
// rtl/pipe_if_pc_bpred.sv - fetch PC register with BTB-steered next-PC and redirect override
module pipe_if_pc_bpred
    import pipe_if_pc_bpred_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          IDX_BITS = IDX_BITS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wpcir,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        pre_taken_if,
    output logic [31:0] pre_bjpc_if
);

    logic [31:0] r_pc;
    logic [31:0] w_pc4;
    logic        w_taken;
    logic [31:0] w_tgt;
    logic [31:0] w_next_pc;

    bpred_btb #(
        .IDX_BITS (IDX_BITS)
    ) u_btb (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_rd_pc      (r_pc),
        .o_rd_taken   (w_taken),
        .o_rd_tgt     (w_tgt),
        .i_upd_valid  (upd_valid),
        .i_upd_pc     (upd_pc),
        .i_upd_taken  (upd_taken),
        .i_upd_target (upd_target)
    );

    assign w_pc4        = r_pc + 32'd4;
    assign pc           = r_pc;
    assign pc4          = w_pc4;
    assign pre_taken_if = w_taken;
    assign pre_bjpc_if  = w_taken ? w_tgt : w_pc4;

    // Redirect wins over both the prediction and a stall.
    assign w_next_pc = redirect ? {redirect_pc[31:2], 2'b00} : pre_bjpc_if;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (wpcir || redirect) begin
            r_pc <= w_next_pc;
        end
    end

endmodule
